mem_port_arbiter: RTL and testbench

- Shares the CPU's single-ported memory between the instruction-fetch stage and the MEM stage (loads/stores).
- Sequences every access with a req/ready handshake and returns the fetched word to IF as `instruction_read_data` with an `instruction_valid` pulse.
- Supports fetch-kill on taken jumps.
- Sits between the pipeline stages and the memory/bus port.

---
 rtl/cpu_mem_pkg.sv | 8 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_arb_fair_cnt.sv | 21 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and constants for the memory-port arbiter
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W = DATA_W_DEF / 8;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = cpu_mem_pkg::DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              instruction_valid;
  logic [DATA_W-1:0] instruction_read_data;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output instruction_valid, instruction_read_data, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport slave (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  instruction_valid, instruction_read_data, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arb_fair_cnt.sv
// mem_arb_fair_cnt: counts data grants made while a fetch waits and flags when the fetch must win
module mem_arb_fair_cnt import cpu_mem_pkg::*; #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_req,
  input  logic grant_i,
  input  logic grant_d,
  output logic ovr
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (grant_i || (idle && !if_req)) cnt <= '0;
    else if (grant_d && if_req && !ovr) cnt <= cnt + 1'b1;
  end
  assign ovr = cnt == W'(LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store, data first.
// Define ARB_FAIR_EN to let a waiting fetch win after FAIR_LIMIT consecutive data grants.
module mem_port_arbiter import cpu_mem_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.master bus
);
  state_t state, state_n;
  logic fetch_kill, kill_n, grant_i, grant_d, fair_ovr;
  logic req_n, we_n, iv_n, dv_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, ird_n, drd_n;
  logic [DATA_W/8-1:0] be_n;

  if (FAIR_LIMIT < 1) begin : g_bad_limit
    $error("FAIR_LIMIT must be at least 1");
  end

`ifdef ARB_FAIR_EN
  mem_arb_fair_cnt #(.LIMIT(FAIR_LIMIT)) u_fair (
    .clk(clk), .rst_n(rst_n), .idle(state == IDLE), .if_req(bus.if_req),
    .grant_i(grant_i), .grant_d(grant_d), .ovr(fair_ovr)
  );
`else
  assign fair_ovr = 1'b0;
`endif

  always_comb begin
    state_n = state;
    kill_n  = fetch_kill;
    req_n   = bus.mem_req;
    we_n    = bus.mem_we;
    addr_n  = bus.mem_addr;
    wdata_n = bus.mem_wdata;
    be_n    = bus.mem_be;
    ird_n   = bus.instruction_read_data;
    drd_n   = bus.d_rdata;
    iv_n    = 1'b0;
    dv_n    = 1'b0;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        grant_i = bus.if_req && !bus.if_flush && (!bus.d_req || fair_ovr);
        grant_d = bus.d_req && !grant_i;
        if (grant_d) begin
          req_n   = 1'b1;
          we_n    = bus.d_we;
          addr_n  = bus.d_addr;
          wdata_n = bus.d_wdata;
          be_n    = bus.d_be;
          state_n = D_WAIT;
        end else if (grant_i) begin
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = bus.if_addr;
          be_n    = '1;
          state_n = I_WAIT;
        end
      end
      I_WAIT: begin
        // a flush landing together with mem_ready still kills the word
        kill_n = fetch_kill || bus.if_flush;
        if (bus.mem_ready) begin
          req_n   = 1'b0;
          iv_n    = !kill_n;
          ird_n   = kill_n ? bus.instruction_read_data : bus.mem_rdata;
          state_n = RESP;
        end
      end
      D_WAIT: begin
        if (bus.mem_ready) begin
          req_n   = 1'b0;
          dv_n    = 1'b1;
          drd_n   = bus.mem_we ? bus.d_rdata : bus.mem_rdata;
          state_n = RESP;
        end
      end
      RESP: begin
        kill_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      fetch_kill                <= 1'b0;
      bus.mem_req               <= 1'b0;
      bus.mem_we                <= 1'b0;
      bus.mem_addr              <= '0;
      bus.mem_wdata             <= '0;
      bus.mem_be                <= '0;
      bus.instruction_valid     <= 1'b0;
      bus.instruction_read_data <= DATA_W'(NOP_INSTR);
      bus.d_valid               <= 1'b0;
      bus.d_rdata               <= '0;
    end else begin
      state                     <= state_n;
      fetch_kill                <= kill_n;
      bus.mem_req               <= req_n;
      bus.mem_we                <= we_n;
      bus.mem_addr              <= addr_n;
      bus.mem_wdata             <= wdata_n;
      bus.mem_be                <= be_n;
      bus.instruction_valid     <= iv_n;
      bus.instruction_read_data <= ird_n;
      bus.d_valid               <= dv_n;
      bus.d_rdata               <= drd_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic checked every cycle against a transaction-level model
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;
  localparam int LIM = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Transaction model: who owns the port, whether the answer is being delivered, whether it was killed.
  int owner = 0;
  bit responding = 1'b0;
  bit killed = 1'b0;
  int streak = 0;
  bit fetch_wins;
  logic e_req = 1'b0, e_we = 1'b0, e_iv = 1'b0, e_dv = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ird = NOP_INSTR, e_drd = '0;
  logic [3:0] e_be = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; responding = 1'b0; killed = 1'b0; streak = 0;
      e_req = 1'b0; e_we = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
      e_addr = '0; e_wdata = '0; e_be = '0; e_ird = NOP_INSTR; e_drd = '0;
    end else begin
      e_iv = 1'b0;
      e_dv = 1'b0;
      if (responding) begin
        responding = 1'b0; owner = 0; killed = 1'b0;
      end else if (owner != 0) begin
        if (owner == 1 && bus.if_flush) killed = 1'b1;
        if (bus.mem_ready) begin
          responding = 1'b1;
          e_req = 1'b0;
          if (owner == 1 && !killed) begin e_iv = 1'b1; e_ird = bus.mem_rdata; end
          if (owner == 2) begin e_dv = 1'b1; if (!e_we) e_drd = bus.mem_rdata; end
        end
      end else begin
        fetch_wins = bus.if_req && !bus.if_flush && (!bus.d_req || (FAIR && streak == LIM));
        if (fetch_wins) begin
          owner = 1; e_req = 1'b1; e_we = 1'b0; e_addr = bus.if_addr; e_be = 4'hF; streak = 0;
        end else if (bus.d_req) begin
          owner = 2; e_req = 1'b1; e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_be = bus.d_be;
          if (bus.if_req && streak < LIM) streak++;
        end
        if (!bus.if_req) streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    chkb("cmp_mem_req", bus.mem_req, e_req);
    if (e_req) begin
      chkb("cmp_mem_we", bus.mem_we, e_we);
      chk("cmp_mem_addr", bus.mem_addr, e_addr);
      chk("cmp_mem_be", {28'h0, bus.mem_be}, {28'h0, e_be});
      if (e_we) chk("cmp_mem_wdata", bus.mem_wdata, e_wdata);
    end
    chkb("cmp_instruction_valid", bus.instruction_valid, e_iv);
    chk("cmp_instruction_read_data", bus.instruction_read_data, e_ird);
    chkb("cmp_d_valid", bus.d_valid, e_dv);
    chk("cmp_d_rdata", bus.d_rdata, e_drd);
  end

  task automatic new_d();
    bus.d_req = 1'b1;
    bus.d_we = 1'($urandom_range(0, 1));
    bus.d_addr = $urandom & 32'hFFFC;
    bus.d_wdata = $urandom;
    bus.d_be = 4'($urandom_range(0, 15));
  endtask

  int nd, niv;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ird", bus.instruction_read_data, 32'h0000_0013);
    chkb("reset_mem_req", bus.mem_req, 1'b0);

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(negedge clk);
    chkb("t1_req", bus.mem_req, 1'b1);
    chk("t1_addr", bus.mem_addr, 32'h10);
    chkb("t1_we", bus.mem_we, 1'b0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chkb("t1_iv", bus.instruction_valid, 1'b1);
    chk("t1_ird", bus.instruction_read_data, 32'h0050_0093);
    chk("t1_model_ird", e_ird, 32'h0050_0093);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chkb("t1_one_pulse", bus.instruction_valid, 1'b0);

    // contention: data first, then the fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    @(negedge clk);
    chk("t2_data_addr", bus.mem_addr, 32'h100);
    chkb("t2_data_we", bus.mem_we, 1'b0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chkb("t2_dv", bus.d_valid, 1'b1);
    chk("t2_drd", bus.d_rdata, 32'h1111_2222);
    chkb("t2_gap", bus.mem_req, 1'b0);
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chkb("t2_gap_idle", bus.mem_req, 1'b0);
    @(negedge clk);
    chkb("t2_fetch_req", bus.mem_req, 1'b1);
    chk("t2_fetch_addr", bus.mem_addr, 32'h20);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A0_0113;
    @(negedge clk);
    chkb("t2_iv", bus.instruction_valid, 1'b1);
    chk("t2_ird", bus.instruction_read_data, 32'h00A0_0113);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);

    // flush during a slow fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    @(negedge clk);
    chk("t3_addr", bus.mem_addr, 32'h30);
    bus.if_flush = 1'b1;
    @(negedge clk);
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    chkb("t3_hold1", bus.mem_req, 1'b1);
    @(negedge clk);
    chkb("t3_hold2", bus.mem_req, 1'b1);
    @(negedge clk);
    chk("t3_hold_addr", bus.mem_addr, 32'h30);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chkb("t3_killed", bus.instruction_valid, 1'b0);
    chk("t3_ird_kept", bus.instruction_read_data, 32'h00A0_0113);
    chkb("t3_req_drop", bus.mem_req, 1'b0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    @(negedge clk);
    chk("t3_addr2", bus.mem_addr, 32'h80);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0517;
    @(negedge clk);
    chkb("t3_iv2", bus.instruction_valid, 1'b1);
    chk("t3_ird2", bus.instruction_read_data, 32'h0000_0517);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);

    // store with mem_ready two cycles late
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("t4_req", bus.mem_req, 1'b1);
      chkb("t4_we", bus.mem_we, 1'b1);
      chk("t4_addr", bus.mem_addr, 32'h200);
      chk("t4_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("t4_be", {28'h0, bus.mem_be}, 32'h3);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chkb("t4_dv", bus.d_valid, 1'b1);
    chk("t4_drd_kept", bus.d_rdata, 32'h1111_2222);
    chk("t4_model_drd", e_drd, 32'h1111_2222);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chkb("t4_one_pulse", bus.d_valid, 1'b0);

    // asynchronous reset in the middle of a load
    bus.d_req = 1'b1; bus.d_addr = 32'h300;
    @(negedge clk);
    chkb("t5_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("t5_rst_req", bus.mem_req, 1'b0);
    chk("t5_rst_ird", bus.instruction_read_data, 32'h0000_0013);
    chk("t5_rst_drd", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chkb("t5_no_dv", bus.d_valid, 1'b0);
    end

    // fairness: both requesters held
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0010_0073;
    nd = 0; niv = 0;
`ifdef ARB_FAIR_EN
    for (int i = 0; i < 30 && niv == 0; i++) begin
      @(negedge clk);
      if (bus.d_valid) nd++;
      if (bus.instruction_valid) niv++;
    end
    chk("t6_data_before_fetch", nd, LIM);
    chk("t6_fetch", niv, 1);
`else
    repeat (24) begin
      @(negedge clk);
      if (bus.d_valid) nd++;
      if (bus.instruction_valid) niv++;
    end
    chk("t6_data_count", nd, 8);
    chk("t6_fetch_starved", niv, 0);
    bus.d_req = 1'b0;
    for (int i = 0; i < 10 && niv == 0; i++) begin
      @(negedge clk);
      if (bus.instruction_valid) niv++;
    end
    chk("t6_fetch", niv, 1);
`endif
    chk("t6_ird", bus.instruction_read_data, 32'h0010_0073);
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // random traffic from well-behaved requesters and a memory with random latency
    repeat (3000) begin
      @(negedge clk);
      if (bus.instruction_valid || bus.if_flush) begin
        bus.if_req = 1'($urandom_range(0, 1));
        bus.if_addr = $urandom & 32'hFFFC;
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = $urandom & 32'hFFFC;
      end
      bus.if_flush = ($urandom_range(0, 9) == 0);
      if (bus.d_valid) begin
        if ($urandom_range(0, 1) == 1) new_d();
        else bus.d_req = 1'b0;
      end else if (!bus.d_req && $urandom_range(0, 3) == 0) new_d();
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
